// File: rtl/fd_pkg.sv
// Shared types and constants for the run-time frequency divider controller.
package fd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fd_state_e;

  localparam int unsigned MIN_DIV = 32'd2;

  // Length of the high phase for ratio n; odd ratios get the extra cycle high.
  function automatic int unsigned fd_high_len(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/fd_cfg_hold.sv
// Ratio handshake: validates requested ratios and holds one pending ratio until the
// divider reaches a period boundary.
module fd_cfg_hold
  import fd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             direct,
  input  logic             apply,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             acc_ok,
  output logic             pend_vld,
  output logic [CNT_W-1:0] pend_div
);

  logic             xfer_s;
  logic             div_ok_s;
  logic             cfg_err_d, cfg_err_q;
  logic             pend_vld_d, pend_vld_q;
  logic [CNT_W-1:0] pend_div_d, pend_div_q;

  // Accept/reject decision and pending-register next state.
  always_comb begin
    xfer_s     = cfg_valid & ~pend_vld_q;
    div_ok_s   = (32'(cfg_div) >= MIN_DIV);
    acc_ok     = xfer_s & div_ok_s;
    cfg_err_d  = xfer_s & ~div_ok_s;
    pend_vld_d = pend_vld_q;
    pend_div_d = pend_div_q;
    if (apply) begin
      pend_vld_d = 1'b0;
    end else if (acc_ok && !direct) begin
      pend_vld_d = 1'b1;
      pend_div_d = cfg_div;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  // Handshake state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_div_q <= {CNT_W{1'b0}};
    end else begin
      cfg_err_q  <= cfg_err_d;
      pend_vld_q <= pend_vld_d;
      pend_div_q <= pend_div_d;
    end
  end

  assign cfg_ready = ~pend_vld_q;
  assign cfg_err   = cfg_err_q;
  assign pend_vld  = pend_vld_q;
  assign pend_div  = pend_div_q;

endmodule

// File: rtl/fd_ratio_ctrl.sv
// Run-time divider controller: start/stop sequencing, period counter, and ratio
// changes applied only at output-period boundaries.
module fd_ratio_ctrl
  import fd_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

  fd_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] cur_div_d, cur_div_q;
  logic             clk_out_d, clk_out_q;
  logic             tick_d, tick_q;
  logic             busy_d, busy_q;

  logic             idle_s;
  logic             at_bnd_s;
  logic             run_nxt_s;
  logic             apply_s;
  logic             acc_ok_s;
  logic             pend_vld_s;
  logic [CNT_W-1:0] pend_div_s;

  assign idle_s = (state_q == ST_IDLE);

  fd_cfg_hold #(
    .CNT_W (CNT_W)
  ) u_cfg_hold (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .direct    (idle_s),
    .apply     (apply_s),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .acc_ok    (acc_ok_s),
    .pend_vld  (pend_vld_s),
    .pend_div  (pend_div_s)
  );

  // Next state, period count and ratio; outputs are derived from the next cycle's count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    apply_s   = 1'b0;
    run_nxt_s = 1'b0;
    at_bnd_s  = (cnt_q == (cur_div_q - ONE_C));

    case (state_q)
      ST_IDLE: begin
        // A ratio left pending by a boundary-edge transfer while draining lands here.
        if (acc_ok_s) begin
          cur_div_d = cfg_div;
        end else if (pend_vld_s) begin
          cur_div_d = pend_div_s;
          apply_s   = 1'b1;
        end else begin
          cur_div_d = cur_div_q;
        end
        cnt_d = ZERO_C;
        if (en) begin
          state_d   = ST_RUN;
          run_nxt_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (at_bnd_s) begin
          cnt_d = ZERO_C;
          if (pend_vld_s) begin
            cur_div_d = pend_div_s;
            apply_s   = 1'b1;
          end else begin
            cur_div_d = cur_div_q;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end

        if (en) begin
          state_d   = ST_RUN;
          run_nxt_s = 1'b1;
        end else if (at_bnd_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DRAIN;
          run_nxt_s = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_C;
      end
    endcase

    busy_d    = run_nxt_s;
    tick_d    = run_nxt_s && (cnt_d == ZERO_C);
    clk_out_d = run_nxt_s && (32'(cnt_d) < fd_high_len(32'(cur_div_d)));
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= ZERO_C;
      cur_div_q <= DEF_DIV_C;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
    end
  end

  assign cur_div = cur_div_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fd_ratio_ctrl.sv
// Directed, table-driven bench for fd_ratio_ctrl with hand-computed expectations.
module tb_fd_ratio_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic [7:0] cur_div;
  logic       clk_out;
  logic       tick;
  logic       busy;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic       clk_o;
    logic       tick;
    logic       busy;
    logic       rdy;
    logic       err;
    logic [7:0] cdiv;
  } vec_t;

  vec_t tbl[$];

  fd_ratio_ctrl #(
    .CNT_W   (8),
    .DEF_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int e, input int v, input int d, input int c,
                              input int t, input int b, input int r, input int er,
                              input int cd);
    vec_t x;
    x.en    = e[0];
    x.vld   = v[0];
    x.div   = d[7:0];
    x.clk_o = c[0];
    x.tick  = t[0];
    x.busy  = b[0];
    x.rdy   = r[0];
    x.err   = er[0];
    x.cdiv  = cd[7:0];
    return x;
  endfunction

  task automatic chk(input string tag, input int idx, input string sig, input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s got %0d exp %0d", tag, idx, sig, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input vec_t v);
    chk(tag, idx, "clk_out", int'(clk_out), int'(v.clk_o));
    chk(tag, idx, "tick", int'(tick), int'(v.tick));
    chk(tag, idx, "busy", int'(busy), int'(v.busy));
    chk(tag, idx, "cfg_ready", int'(cfg_ready), int'(v.rdy));
    chk(tag, idx, "cfg_err", int'(cfg_err), int'(v.err));
    chk(tag, idx, "cur_div", int'(cur_div), int'(v.cdiv));
  endtask

  // Drive inputs for one edge, then check the registered outputs just after it.
  task automatic step(input string tag, input int idx, input vec_t v);
    en        = v.en;
    cfg_valid = v.vld;
    cfg_div   = v.div;
    @(posedge clk);
    #1;
    check_outs(tag, idx, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    rst       = 1'b1;
    #2 rst    = 1'b0;

    // fields: en vld div | clk_out tick busy cfg_ready cfg_err cur_div
    // default ratio 4: high 2, low 2
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,4));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,4));
    // ratios 1 and 0 rejected while running
    tbl.push_back(mk(1,1,1, 0,0,1,1,1,4));
    tbl.push_back(mk(1,1,0, 0,0,1,1,1,4));
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,4));
    // stop at k=1: period completes, then idle
    tbl.push_back(mk(0,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(0,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(0,0,0, 0,0,0,1,0,4));
    tbl.push_back(mk(0,0,0, 0,0,0,1,0,4));
    // stop at k=1, resume at k=2: no missing period
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,4));
    tbl.push_back(mk(0,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,4));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,4));
    // ratio 6 offered while draining, lands on the final boundary
    tbl.push_back(mk(0,0,0, 0,0,1,1,0,4));
    tbl.push_back(mk(0,1,6, 0,0,1,0,0,4));
    tbl.push_back(mk(0,0,0, 0,0,0,1,0,6));
    // ratio 5 loaded directly in idle: high 3, low 2
    tbl.push_back(mk(0,1,5, 0,0,0,1,0,5));
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,5));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,5));
    tbl.push_back(mk(1,0,0, 1,0,1,1,0,5));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,5));
    tbl.push_back(mk(1,0,0, 0,0,1,1,0,5));
    tbl.push_back(mk(1,0,0, 1,1,1,1,0,5));
    // drain, ratio 4 pending, back to idle with 4
    tbl.push_back(mk(0,0,0, 1,0,1,1,0,5));
    tbl.push_back(mk(0,0,0, 1,0,1,1,0,5));
    tbl.push_back(mk(0,0,0, 0,0,1,1,0,5));
    tbl.push_back(mk(0,1,4, 0,0,1,0,0,5));
    tbl.push_back(mk(0,0,0, 0,0,0,1,0,4));

    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 0, mk(0,0,0, 0,0,0,1,0,4));
    rst = 1'b1;

    foreach (tbl[i]) step("tbl", i, tbl[i]);

    // ratio 6 transferred at k=1 of a 4-period: current period keeps 4
    step("t3", 0, mk(1,0,0, 1,1,1,1,0,4));
    step("t3", 1, mk(1,0,0, 1,0,1,1,0,4));
    step("t3", 2, mk(1,1,6, 0,0,1,0,0,4));
    step("t3", 3, mk(1,0,0, 0,0,1,0,0,4));
    for (int k = 0; k < 6; k++)
      step("t3_n6", k, mk(1,0,0, int'(k < 3), int'(k == 0), 1,1,0,6));
    // ratio 4 transferred on the boundary edge: lands one period later
    step("t3_bnd", 0, mk(1,1,4, 1,1,1,0,0,6));
    for (int k = 1; k < 6; k++)
      step("t3_bnd", k, mk(1,0,0, int'(k < 3), 0, 1,0,0,6));
    for (int k = 0; k < 4; k++)
      step("t3_n4", k, mk(1,0,0, int'(k < 2), int'(k == 0), 1,1,0,4));

    // reach a 6-period with ratio 7 pending, then reset mid high phase
    step("t6", 0, mk(1,1,6, 1,1,1,0,0,4));
    step("t6", 1, mk(1,0,0, 1,0,1,0,0,4));
    step("t6", 2, mk(1,0,0, 0,0,1,0,0,4));
    step("t6", 3, mk(1,0,0, 0,0,1,0,0,4));
    step("t6", 4, mk(1,0,0, 1,1,1,1,0,6));
    step("t6", 5, mk(1,1,7, 1,0,1,0,0,6));
    en        = 1'b0;
    cfg_valid = 1'b0;
    #3 rst    = 1'b0;
    #1;
    check_outs("t6_async", 0, mk(0,0,0, 0,0,0,1,0,4));
    #2;
    @(negedge clk);
    rst = 1'b1;
    step("t6_idle", 0, mk(0,0,0, 0,0,0,1,0,4));
    step("t6_idle", 1, mk(0,0,0, 0,0,0,1,0,4));
    for (int k = 0; k < 5; k++)
      step("t6_run", k, mk(1,0,0, int'((k % 4) < 2), int'((k % 4) == 0), 1,1,0,4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
